// File: rtl/sram_port_initiator.sv
// Initiator for a single-port byte-enabled SRAM with registered read address, plus a bulk-clear sequencer.
// Optional macro SRAM_PORT_INIT_ON_RESET_EN: run a full clear automatically after reset release.
module sram_port_initiator #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 44,
  parameter int BW    = (WIDTH - 1) / 8 + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [BW-1:0]    req_bwe,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             sram_ce,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [WIDTH-1:0] sram_din,
  output logic [BW-1:0]    sram_bwe,
  input  logic [WIDTH-1:0] sram_dout
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid must hold its payload until that edge, and ready may depend on the other side's valid.

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

`ifdef SRAM_PORT_INIT_ON_RESET_EN
  localparam logic CLEAR_PEND_RST = 1'b1;
`else
  localparam logic CLEAR_PEND_RST = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clear_pend_q, clear_pend_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          clear_done_q, clear_done_d;
  logic          rsp_free;
  logic          req_fire;

  // A stalled response blocks new SRAM cycles so the registered read address, and thus dout, stays put.
  assign rsp_free   = ~rsp_valid_q | rsp_ready;
  assign req_ready  = reset_n & (state_q == IDLE) & ~clear_pend_q & rsp_free;
  assign req_fire   = req_valid & req_ready;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = sram_dout;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clear_pend_d = clear_pend_q;
    rsp_valid_d  = rsp_valid_q;
    clear_done_d = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (req_fire && !req_we) begin
      rsp_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clear_pend_q) begin
          if (rsp_free) begin
            state_d      = CLEAR;
            idx_d        = '0;
            clear_pend_d = 1'b0;
          end
        end else if (clear_start) begin
          clear_pend_d = 1'b1;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d      = IDLE;
          idx_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    sram_bwe  = '0;
    if (state_q == CLEAR) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = idx_q;
      sram_bwe  = '1;
    end else if (req_fire) begin
      sram_ce   = 1'b1;
      sram_we   = req_we;
      sram_addr = req_addr;
      sram_din  = req_wdata;
      sram_bwe  = req_bwe;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      clear_pend_q <= CLEAR_PEND_RST;
      rsp_valid_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_pend_q <= clear_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      clear_done_q <= clear_done_d;
    end
  end

endmodule

// File: tb/tb_sram_port_initiator.sv
// Self-checking bench for sram_port_initiator: behavioural SRAM, memory/queue reference model, directed plus random steps.
module tb_sram_port_initiator;

  localparam int DEPTH = 64;
  localparam int WIDTH = 44;
  localparam int BW    = 6;
  localparam int AW    = 6;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [BW-1:0]    req_bwe;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             clear_start;
  logic             clear_busy;
  logic             clear_done;
  logic             sram_ce;
  logic             sram_we;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_din;
  logic [BW-1:0]    sram_bwe;
  logic [WIDTH-1:0] sram_dout;

  sram_port_initiator #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bwe(req_bwe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_bwe(sram_bwe), .sram_dout(sram_dout)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural SRAM ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_addr_q;

  always @(posedge clk) begin : sram_model
    logic [WIDTH-1:0] w;
    if (sram_ce && sram_we) begin
      w = mem[sram_addr];
      for (int i = 0; i < WIDTH; i++) if (sram_bwe[i/8]) w[i] = sram_din[i];
      mem[sram_addr] <= w;
    end else if (sram_ce) begin
      rd_addr_q <= sram_addr;
    end
  end
  assign sram_dout = mem[rd_addr_q];

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] exp_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   fire_cnt = 0;
  int   clr_idx = 0;
  int   clr_done_cnt = 0;
  logic last_hs = 1'b0;
  logic last_fire = 1'b0;
  logic last_done = 1'b0;

  function automatic logic [WIDTH-1:0] byte_mask(input logic [BW-1:0] bwe);
    logic [8*BW-1:0] m;
    m = '0;
    for (int b = 0; b < BW; b++) if (bwe[b]) m[8*b +: 8] = 8'hFF;
    return m[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge+1, update the model, then return at the next negedge.
  task automatic cyc();
    logic [WIDTH-1:0] m;
    #1;
    last_hs   = req_valid & req_ready;
    last_fire = rsp_valid & rsp_ready;
    last_done = clear_done;
    if (last_fire) begin
      fire_cnt++;
      chk("rsp_has_expectation", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
    end
    if (clear_busy) begin
      chk("clr_ce_we_ready", {61'd0, sram_ce, sram_we, req_ready}, 64'b110);
      chk("clr_addr", 64'(sram_addr), 64'(clr_idx));
      chk("clr_din_bwe", {14'd0, sram_din, sram_bwe}, {14'd0, 44'd0, 6'h3F});
      clr_idx++;
    end
    if (clear_done) begin
      clr_done_cnt++;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    end
    if (last_hs) begin
      if (req_we) begin
        m = byte_mask(req_bwe);
        exp_mem[req_addr] = (exp_mem[req_addr] & ~m) | (req_wdata & m);
      end else begin
        exp_q.push_back(exp_mem[req_addr]);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d, input logic [BW-1:0] b);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_bwe   = b;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [BW-1:0] b);
    drive_req(we, a, d, b);
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (last_hs) break;
    end
    chk("send_accepted", 64'(last_hs), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) cyc();
    chk("rsp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed and random steps ----------------
  initial begin : stim
    int d0;
    int f0;
    logic [WIDTH-1:0] v;

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_bwe = '0; rsp_ready = 1'b1; clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = rnd_word();
      mem[i] = v;
      exp_mem[i] = v;
    end

    // Reset values, with a request presented to prove it is gated.
    @(negedge clk);
    drive_req(1'b1, 6'd3, 44'hFFF_FFFF_FFFF, 6'h3F);
    #1;
    chk("rst_ctrl", {58'd0, rsp_valid, clear_busy, clear_done, sram_ce, sram_we, req_ready}, 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_din", 64'(sram_din), 64'd0);
    chk("rst_bwe", 64'(sram_bwe), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_busy", 64'(clear_busy), 64'd0);

    // Full write then read-back, one-cycle latency.
    send(1'b1, 6'd5, 44'hABC_DEF0_1234, 6'h3F);
    send(1'b0, 6'd5, '0, '0);
    #1;
    chk("t1_rsp_valid_latency", 64'(rsp_valid), 64'd1);
    chk("t1_rdata", 64'(rsp_rdata), 64'h0ABC_DEF0_1234);
    cyc();
    #1;
    chk("t1_rsp_valid_drop", 64'(rsp_valid), 64'd0);

    // Partial write: byte 0 and the 4-bit top byte only.
    send(1'b1, 6'd5, '0, 6'b100001);
    send(1'b0, 6'd5, '0, '0);
    #1;
    chk("t2_rdata_partial", 64'(rsp_rdata), 64'h00BC_DEF0_1200);
    cyc();

    // Stalled response with a waiting request.
    rsp_ready = 1'b0;
    send(1'b0, 6'd5, '0, '0);
    drive_req(1'b0, 6'd6, '0, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_stall_req_ready", 64'(req_ready), 64'd0);
      chk("t3_stall_ce", 64'(sram_ce), 64'd0);
      chk("t3_stall_valid", 64'(rsp_valid), 64'd1);
      chk("t3_stall_rdata", 64'(rsp_rdata), 64'h00BC_DEF0_1200);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_release_req_ready", 64'(req_ready), 64'd1);
    chk("t3_release_issue", {56'd0, sram_ce, sram_we, sram_addr}, {56'd0, 1'b1, 1'b0, 6'd6});
    cyc();
    req_valid = 1'b0;
    wait_rsp();

    // Back-to-back reads, one per cycle.
    f0 = fire_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, AW'(i), '0, '0);
      if (i > 0) begin
        #1;
        chk("t4_rsp_valid_no_bubble", 64'(rsp_valid), 64'd1);
      end
      cyc();
      chk("t4_issue_each_cycle", 64'(last_hs), 64'd1);
    end
    req_valid = 1'b0;
    cyc();
    chk("t4_rsp_count", 64'(fire_cnt - f0), 64'd8);
    #1;
    chk("t4_rsp_valid_end", 64'(rsp_valid), 64'd0);

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      if (!req_valid || last_hs) begin
        if ($urandom_range(0, 3) != 0)
          drive_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                    rnd_word(), BW'($urandom_range(0, 63)));
        else
          req_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp();

    // Clear requested while a response is stalled.
    rsp_ready = 1'b0;
    send(1'b0, 6'd63, '0, '0);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_wait_busy", 64'(clear_busy), 64'd0);
      chk("t5_wait_ce", 64'(sram_ce), 64'd0);
      cyc();
    end
    drive_req(1'b0, 6'd7, '0, '0);
    rsp_ready = 1'b1;
    #1;
    chk("t5_clear_priority", 64'(req_ready), 64'd0);
    chk("t5_not_yet_busy", 64'(clear_busy), 64'd0);
    clr_idx = 0;
    d0 = clr_done_cnt;
    cyc();
    for (int k = 0; k < 200; k++) begin
      clear_start = (clr_idx == 20);
      cyc();
      if (clr_done_cnt != d0) break;
    end
    clear_start = 1'b0;
    chk("t5_clear_write_count", 64'(clr_idx), 64'd64);
    chk("t5_done_seen", 64'(clr_done_cnt - d0), 64'd1);
    chk("t5_req_after_clear", 64'(last_hs), 64'd1);
    req_valid = 1'b0;
    cyc();
    chk("t5_done_one_cycle", 64'(last_done), 64'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_no_second_clear", 64'(clear_busy), 64'd0);
      cyc();
    end
    send(1'b0, 6'd0, '0, '0);
    #1;
    chk("t5_read0_zero", 64'(rsp_rdata), 64'd0);
    cyc();
    send(1'b0, 6'd63, '0, '0);
    #1;
    chk("t5_read63_zero", 64'(rsp_rdata), 64'd0);
    cyc();

    // Reset in the middle of a clear.
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    clr_idx = 0;
    for (int k = 0; k < 200 && clr_idx != 30; k++) cyc();
    chk("t6_reached_idx30", 64'(clr_idx), 64'd30);
    #1;
    chk("t6_busy_at_idx30", {57'd0, clear_busy, sram_addr}, {57'd0, 1'b1, 6'd30});
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {58'd0, rsp_valid, clear_busy, clear_done, sram_ce, sram_we, req_ready}, 64'd0);
    chk("t6_rst_addr_din_bwe", {8'd0, sram_addr, sram_din, sram_bwe}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = clr_done_cnt;
    clr_idx = 0;
    cyc();
    #1;
    chk("t6_req_ready_after_release", 64'(req_ready), 64'd1);
    for (int k = 0; k < 80; k++) cyc();
    chk("t6_no_clear_done", 64'(clr_done_cnt - d0), 64'd0);
    chk("t6_no_clear_activity", 64'(clr_idx), 64'd0);
    v = rnd_word();
    send(1'b1, 6'd30, v, 6'h3F);
    send(1'b0, 6'd30, '0, '0);
    #1;
    chk("t6_rw_after_reset", 64'(rsp_rdata), 64'(v));
    cyc();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
